keypad_scan_ctrl: RTL and testbench



---
 rtl/keypad_scan_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: column drive, row sync, frame debounce, key-code FIFO, level irq.
// Latency: push in FRAME cycle; key_valid/fifo_count next edge; irq one edge later.
// Backpressure: pops only when key_valid; a push into a full FIFO without a pop is dropped and sets overflow.
module keypad_scan_ctrl #(
  parameter int CLK_DIV         = 1000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       axi_aclk,
  input  logic       axi_areset,
  input  logic       enable,
  input  logic       irq_en,
  input  logic       clear_ovf,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] col_oe,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_ready,
  output logic [4:0] fifo_count,
  output logic       overflow,
  output logic       irq
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_FRAME} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_col, w_col_nxt;
  logic [DW-1:0] r_div, w_div_nxt;
  logic [3:0]    r_row_s1, r_row_s2;
  logic [15:0]   r_mat;          // bit col*4+row: row sense latched for that column
  logic [7:0]    r_stable_cnt, w_stable_nxt;
  logic          r_reported;
  logic          r_prev_none;
  logic [3:0]    r_prev_code;
  logic          w_cand_none;
  logic [3:0]    w_cand_code;
  logic          w_same, w_key_change, w_rep_eff, w_eval, w_push;
  logic          w_pop, w_full, w_wr, w_drop;
  logic [3:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [4:0]    r_count;
  logic          r_ovf, r_irq;

  // Two-flop synchronizer for the asynchronous row lines
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      r_row_s1 <= '0;
      r_row_s2 <= '0;
    end else begin
      r_row_s1 <= row_in;
      r_row_s2 <= r_row_s1;
    end
  end

  // Scan FSM state, column index and settle counter
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_div   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_div   <= w_div_nxt;
    end
  end

  // Scan FSM next state and column drive; enable low always parks in IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_div_nxt   = r_div;
    col_out     = '0;
    col_oe      = {4{r_state != S_IDLE}};
    if (r_state == S_SETTLE || r_state == S_SAMPLE) col_out = 4'b0001 << r_col;
    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_col_nxt   = '0;
      w_div_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_SETTLE;
          w_col_nxt   = '0;
          w_div_nxt   = '0;
        end
        S_SETTLE: begin
          if (r_div == DW'(CLK_DIV - 1)) begin
            w_state_nxt = S_SAMPLE;
            w_div_nxt   = '0;
          end else begin
            w_div_nxt = r_div + DW'(1);
          end
        end
        S_SAMPLE: begin
          if (r_col == 2'd3) begin
            w_state_nxt = S_FRAME;
          end else begin
            w_col_nxt   = r_col + 2'd1;
            w_state_nxt = S_SETTLE;
          end
        end
        S_FRAME: begin
          w_col_nxt   = '0;
          w_state_nxt = S_SETTLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Latch the synchronized rows for the column being sampled
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) r_mat <= '0;
    else if (r_state == S_SAMPLE) r_mat[{r_col, 2'b00} +: 4] <= r_row_s2;
  end

  // Frame candidate (first pressed key, column-major) and debounce decisions
  always_comb begin
    w_cand_none = 1'b1;
    w_cand_code = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (w_cand_none && r_mat[c*4+r]) begin
          w_cand_none = 1'b0;
          w_cand_code = 4'(r*4 + c);
        end
      end
    end
    w_same       = (w_cand_none == r_prev_none) && (w_cand_none || (w_cand_code == r_prev_code));
    w_stable_nxt = !w_same ? 8'd1 : ((r_stable_cnt == 8'hFF) ? 8'hFF : r_stable_cnt + 8'd1);
    // A jump straight to a different key re-arms reporting; bounces through NONE do not
    w_key_change = !w_same && !w_cand_none && !r_prev_none;
    w_rep_eff    = r_reported && !w_key_change;
    w_eval       = enable && (r_state == S_FRAME);
    w_push       = w_eval && !w_cand_none && !w_rep_eff && (w_stable_nxt == 8'(DEBOUNCE_FRAMES));
  end

  // Debounce state, updated once per frame and cleared while disabled
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      r_prev_none  <= 1'b1;
      r_prev_code  <= '0;
      r_stable_cnt <= '0;
      r_reported   <= 1'b0;
    end else if (!enable) begin
      r_prev_none  <= 1'b1;
      r_prev_code  <= '0;
      r_stable_cnt <= '0;
      r_reported   <= 1'b0;
    end else if (w_eval) begin
      r_prev_none  <= w_cand_none;
      r_prev_code  <= w_cand_code;
      r_stable_cnt <= w_stable_nxt;
      if (w_push) r_reported <= 1'b1;
      else if (w_cand_none && (w_stable_nxt == 8'(DEBOUNCE_FRAMES))) r_reported <= 1'b0;
      else r_reported <= w_rep_eff;
    end
  end

  assign w_pop  = key_ready && (r_count != 5'd0);
  assign w_full = (r_count == 5'(FIFO_DEPTH));
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_drop = w_push && w_full && !w_pop;

  // Key-code FIFO storage, pointers and occupancy
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= w_cand_code;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr && !w_pop) r_count <= r_count + 5'd1;
      else if (!w_wr && w_pop) r_count <= r_count - 5'd1;
    end
  end

  // Sticky overflow (a new drop beats clear_ovf) and registered interrupt
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      r_ovf <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_drop) r_ovf <= 1'b1;
      else if (clear_ovf) r_ovf <= 1'b0;
      r_irq <= irq_en && (r_count != 5'd0);
    end
  end

  assign key_valid  = (r_count != 5'd0);
  assign key_code   = r_mem[r_rd_ptr];
  assign fifo_count = r_count;
  assign overflow   = r_ovf;
  assign irq        = r_irq;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl with CLK_DIV=3, DEBOUNCE_FRAMES=2, FIFO_DEPTH=4 (17-cycle frame).
// A keypad model turns the pressed-key matrix plus col_out into row_in.
// Table of press/release records plus hand-timed sequences for bounce, full push+pop and enable drop.
module tb_keypad_scan_ctrl;

  logic       axi_aclk = 1'b0;
  logic       axi_areset, enable, irq_en, clear_ovf, key_ready;
  logic [3:0] row_in, col_out, col_oe, key_code;
  logic       key_valid, overflow, irq;
  logic [4:0] fifo_count;
  logic [15:0] pressed;   // bit row*4+col set = key held down

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] code;
    int         exp_cnt;
    int         exp_ovf;
  } vec_t;
  vec_t tbl[5];

  keypad_scan_ctrl #(.CLK_DIV(3), .DEBOUNCE_FRAMES(2), .FIFO_DEPTH(4)) dut (
    .axi_aclk   (axi_aclk),
    .axi_areset (axi_areset),
    .enable     (enable),
    .irq_en     (irq_en),
    .clear_ovf  (clear_ovf),
    .row_in     (row_in),
    .col_out    (col_out),
    .col_oe     (col_oe),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ready  (key_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .irq        (irq)
  );

  always #5 axi_aclk = ~axi_aclk;

  // Keypad: a row line is high when a pressed key in that row sits on a driven column
  always_comb begin
    row_in = '0;
    for (int r = 0; r < 4; r++) row_in[r] = |(col_out & pressed[r*4 +: 4]);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge axi_aclk);
  endtask

  // Returns at the negedge of the next FRAME cycle (col_out=0 while scanning)
  task automatic wait_frame();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge axi_aclk);
      if (col_out == 4'd0 && col_oe == 4'hF) found = 1'b1;
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL frame_wait: got timeout expected FRAME cycle within 40");
    end
  endtask

  task automatic press_release(input logic [3:0] code);
    pressed = 16'd1 << code;
    cyc(51);
    pressed = '0;
    cyc(51);
  endtask

  task automatic pop_chk(input string nm, input int exp);
    chk({nm, "_valid"}, key_valid, 1);
    chk({nm, "_code"}, key_code, exp);
    key_ready = 1'b1;
    cyc(1);
    key_ready = 1'b0;
  endtask

  initial begin
    tbl[0] = '{4'd9,  1, 0};
    tbl[1] = '{4'd9,  2, 0};
    tbl[2] = '{4'd3,  3, 0};
    tbl[3] = '{4'd6,  4, 0};
    tbl[4] = '{4'd12, 4, 1};

    axi_areset = 1'b1;
    enable     = 1'b0;
    irq_en     = 1'b1;
    clear_ovf  = 1'b0;
    key_ready  = 1'b0;
    pressed    = '0;
    cyc(3);
    chk("rst_col_out", col_out, 0);
    chk("rst_col_oe", col_oe, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_code", key_code, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_irq", irq, 0);
    axi_areset = 1'b0;
    cyc(2);
    chk("idle_col_oe", col_oe, 0);

    // Scan sequence: 1,2,4,8 each for 4 cycles, then 0 for one
    enable = 1'b1;
    for (int k = 0; k < 34; k++) begin
      int idx;
      cyc(1);
      idx = k % 17;
      chk("scan_col_out", col_out, (idx == 16) ? 0 : (1 << (idx / 4)));
    end
    chk("scan_col_oe", col_oe, 4'hF);

    // Bounce on key 0, phased so sampled frames read 0,NONE,NONE before the hold
    wait_frame();
    for (int t = 0; t < 8; t++) begin
      pressed = (t % 2 == 0) ? 16'h0001 : 16'h0000;
      cyc(5);
    end
    pressed = 16'h0001;
    chk("bounce_no_push", fifo_count, 0);
    cyc(68);
    chk("bounce_push_cnt", fifo_count, 1);
    pop_chk("bounce_pop", 0);
    pressed = '0;
    cyc(51);
    chk("bounce_drained", fifo_count, 0);

    // Press/release table: repeat press, fill, then a dropped push
    for (int i = 0; i < 5; i++) begin
      press_release(tbl[i].code);
      chk("tbl_fifo_count", fifo_count, tbl[i].exp_cnt);
      chk("tbl_overflow", overflow, tbl[i].exp_ovf);
    end
    chk("full_key_valid", key_valid, 1);
    chk("full_irq", irq, 1);
    irq_en = 1'b0;
    cyc(2);
    chk("irq_masked", irq, 0);
    irq_en = 1'b1;
    cyc(2);
    chk("irq_unmasked", irq, 1);
    clear_ovf = 1'b1;
    cyc(1);
    clear_ovf = 1'b0;
    chk("clear_ovf", overflow, 0);
    chk("clear_ovf_cnt", fifo_count, 4);

    // Full FIFO: pop exactly in the FRAME cycle where key 15 gets pushed
    wait_frame();
    pressed = 16'h8000;
    cyc(34);
    chk("pp_frame_cycle", col_out, 0);
    chk("pp_head", key_code, 9);
    key_ready = 1'b1;
    cyc(1);
    key_ready = 1'b0;
    chk("pp_fifo_count", fifo_count, 4);
    chk("pp_overflow", overflow, 0);
    pressed = '0;
    cyc(51);
    chk("pp_no_repeat", fifo_count, 4);
    pop_chk("pop0", 9);
    pop_chk("pop1", 3);
    pop_chk("pop2", 6);
    pop_chk("pop3", 15);
    chk("empty_valid", key_valid, 0);
    cyc(1);
    chk("empty_irq", irq, 0);

    // Enable dropped mid-SETTLE with two entries queued
    press_release(4'd5);
    press_release(4'd10);
    chk("en_pre_cnt", fifo_count, 2);
    wait_frame();
    cyc(2);
    chk("en_settle_col", col_out, 1);
    enable = 1'b0;
    cyc(1);
    chk("en_off_col_out", col_out, 0);
    chk("en_off_col_oe", col_oe, 0);
    cyc(5);
    chk("en_off_cnt", fifo_count, 2);
    enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      chk("en_restart_col", col_out, (k < 4) ? 1 : 2);
    end
    pop_chk("en_pop0", 5);

    // Reset mid-operation clears the FIFO immediately
    axi_areset = 1'b1;
    #2;
    chk("midrst_cnt", fifo_count, 0);
    chk("midrst_valid", key_valid, 0);
    chk("midrst_col_out", col_out, 0);
    cyc(2);
    axi_areset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
